// File: rtl/suma_bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package suma_bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam int DIG_MAX       = 9;
    localparam int N_DIGITOS_DEF = 4;

    typedef enum logic [1:0] {
        REPOSO,
        SUMANDO,
        LISTO
    } estado_suma_t;

    // True when a nibble is a legal decimal digit.
    function automatic logic es_bcd(input bcd_t d);
        return (d <= bcd_t'(DIG_MAX));
    endfunction

endpackage

// File: rtl/suma_digito_bcd.sv
// One-digit BCD adder: d/cout from a + b + cin with decimal correction.
module suma_digito_bcd
    import suma_bcd_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t d,
    output logic cout
);

    logic [4:0] s;

    // Binary sum, then subtract ten and raise the carry when the sum leaves the decimal range.
    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'(DIG_MAX)) begin
            d    = 4'(s - 5'd10);
            cout = 1'b1;
        end else begin
            d    = s[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/suma_bcd_serial.sv
// Digit-serial BCD adder, least significant digit first.
// Operands are captured on the suma pulse and summed one digit per clock
// through a single shared digit adder; the (N_DIGITOS+1)-digit result is
// held with valido until the next request or a reset.
// Optional build macro SUMA_BCD_CHECK_EN adds the digito_inv port and
// rejects operands containing a non-decimal digit.
module suma_bcd_serial
    import suma_bcd_pkg::*;
#(
    parameter int N_DIGITOS = N_DIGITOS_DEF
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_sv,
    input  bcd_t [N_DIGITOS-1:0]    numero_sv,
    input  bcd_t [N_DIGITOS-1:0]    numero,
    input  logic                    suma,
    output bcd_t [N_DIGITOS:0]      resultado,
    output logic                    ocupado,
    output logic                    valido
`ifdef SUMA_BCD_CHECK_EN
    ,
    output logic                    digito_inv
`endif
);

    localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

    estado_suma_t          estado;
    bcd_t [N_DIGITOS-1:0]  op_a;
    bcd_t [N_DIGITOS-1:0]  op_b;
    logic [IDX_W-1:0]      idx;
    logic                  carry;

    bcd_t dig_a;
    bcd_t dig_b;
    bcd_t dig_s;
    logic dig_cout;
    logic ultimo;

    assign dig_a  = op_a[idx];
    assign dig_b  = op_b[idx];
    assign ultimo = (idx == IDX_W'(N_DIGITOS - 1));

    suma_digito_bcd u_digito (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry),
        .d    (dig_s),
        .cout (dig_cout)
    );

`ifdef SUMA_BCD_CHECK_EN
    logic hay_inv;

    // Flag latched operands that contain any nibble above nine.
    always_comb begin
        hay_inv = 1'b0;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (!es_bcd(op_a[i]) || !es_bcd(op_b[i])) begin
                hay_inv = 1'b1;
            end
        end
    end
`endif

    // Control FSM and datapath: accept, one digit per edge, then hold the result.
    always_ff @(posedge clk) begin
        if (rst || rst_sv) begin
            estado    <= REPOSO;
            op_a      <= '0;
            op_b      <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            resultado <= '0;
            ocupado   <= 1'b0;
            valido    <= 1'b0;
`ifdef SUMA_BCD_CHECK_EN
            digito_inv <= 1'b0;
`endif
        end else begin
            case (estado)
                REPOSO, LISTO: begin
                    if (suma) begin
                        op_a      <= numero_sv;
                        op_b      <= numero;
                        idx       <= '0;
                        carry     <= 1'b0;
                        resultado <= '0;
                        valido    <= 1'b0;
                        ocupado   <= 1'b1;
                        estado    <= SUMANDO;
`ifdef SUMA_BCD_CHECK_EN
                        digito_inv <= 1'b0;
`endif
                    end
                end
                SUMANDO: begin
`ifdef SUMA_BCD_CHECK_EN
                    if (hay_inv) begin
                        resultado  <= '0;
                        valido     <= 1'b1;
                        ocupado    <= 1'b0;
                        digito_inv <= 1'b1;
                        estado     <= LISTO;
                    end else begin
`else
                    begin
`endif
                        resultado[idx] <= dig_s;
                        carry          <= dig_cout;
                        idx            <= idx + 1'b1;
                        if (ultimo) begin
                            resultado[N_DIGITOS] <= {3'b000, dig_cout};
                            valido  <= 1'b1;
                            ocupado <= 1'b0;
                            estado  <= LISTO;
                        end
                    end
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule
